ahb_slave_regs: RTL and testbench
=================================

AHB_SLAVE_REGS -- requirements
Module: ahb_slave_regs

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16, giving the number of 32-bit registers (2..64).
REQ-002 SHALL have parameter WAIT_STATES, default 1, giving the wait cycles inserted per OKAY data phase (0..7).
REQ-003 SHALL have parameter ID_VALUE, default 32'h4E50_5501, giving the read-only content of register 0.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port ahb_hsel_i, input, 1 bit: slave select.
REQ-007 SHALL have port ahb_haddr_i, input, 32 bits: byte address; bits [7:0] decoded, upper bits ignored.
REQ-008 SHALL have ports ahb_hwrite_i (1 bit), ahb_hsize_i (3 bits) and ahb_htrans_i (2 bits), all inputs, carrying AHB-Lite control.
REQ-009 SHALL have ports ahb_hburst_i (3), ahb_hprot_i (4) and ahb_hmastlock_i (1), all inputs, accepted and ignored.
REQ-010 SHALL have port ahb_hwdata_i, input, 32 bits: write data, little-endian byte lanes.
REQ-011 SHALL have ports ahb_hready_o (output, 1), ahb_hresp_o (output, 1; 0=OKAY, 1=ERROR) and ahb_hrdata_o (output, 32).
REQ-012 SHALL have port ctrl_o, output, 32 bits: continuous copy of register 1.

Function
REQ-013 SHALL accept an address phase only when ahb_hsel_i=1, ahb_htrans_i[1]=1 (NONSEQ/SEQ) and ahb_hready_o=1; it registers addr[7:0], hwrite and hsize.
REQ-014 SHALL give IDLE/BUSY transfers, or hsel=0, a zero-wait OKAY response with no register side effects.
REQ-015 SHALL have four FSM states: IDLE, WAIT, ERR1 and ERR2.
REQ-016 SHALL use these transitions: IDLE->WAIT on an accepted legal transfer when WAIT_STATES>0; IDLE->IDLE when WAIT_STATES=0 (the data phase completes in the next cycle); IDLE->ERR1 on an accepted illegal transfer.
REQ-017 SHALL, in WAIT, count WAIT_STATES cycles with hready_o=0 and hresp_o=0, then drive one cycle of hready_o=1 and return to IDLE, or accept a pipelined next transfer in that same cycle.
REQ-018 SHALL treat a transfer as illegal when offset addr[7:2] >= NUM_REGS, or hsize > 3'b010, or the address is misaligned (halfword with addr[0]=1, word with addr[1:0]!=0).
REQ-019 SHALL drive ERR1 as hready_o=0, hresp_o=1, and ERR2 as hready_o=1, hresp_o=1; a new address phase presented during ERR2 is accepted (standard two-cycle ERROR response).
REQ-020 SHALL perform no register write for an illegal transfer, and drive hrdata_o=0 during ERR1/ERR2.
REQ-021 SHALL sample ahb_hwdata_i in the final data-phase cycle (hready_o=1) and update the register at that clock edge.
REQ-022 SHALL write only the byte lanes selected by hsize/addr[1:0]: byte writes lane addr[1:0]; halfword writes lanes {addr[1],0}/+1; word writes all four lanes.
REQ-023 SHALL make register 0 read-only: it always reads ID_VALUE, ignores writes, and returns OKAY.
REQ-024 SHALL drive ahb_hrdata_o with the full 32-bit register word, valid in the final read data-phase cycle; it is 0 in all other cycles.
REQ-025 SHALL return the new value on a read immediately following a write to the same register (write is committed before the read data phase).
REQ-026 SHALL hold hready_o=1 and hresp_o=0 whenever there is no outstanding data phase.

Reset
REQ-027 SHALL, on reset=1 at a clock edge: enter FSM IDLE, clear the wait counter, set all registers 1..NUM_REGS-1 to 0, and drive hready_o=1, hresp_o=0, hrdata_o=0, ctrl_o=0.
REQ-028 SHALL let reset asserted mid-transfer (WAIT/ERR1) abort the transfer with no register write, and accept no transfers while reset=1.

Verification
REQ-029 SHALL be verified with: word write 0xDEADBEEF to 0x04 then read 0x04, WAIT_STATES=1 -> one hready_o=0 cycle per phase, read returns 0xDEADBEEF, ctrl_o=0xDEADBEEF.
REQ-030 SHALL be verified with: byte write 0xAA to 0x09 over 0x11223344 at reg 2 -> reg 2 reads 0x1122AA44; halfword write 0x5566 to 0x0A -> 0x5566AA44.
REQ-031 SHALL be verified with: read 0x40 (NUM_REGS=16), then misaligned word at 0x06 -> each gives ERR1 (hready 0, hresp 1) then ERR2 (hready 1, hresp 1), no registers change.
REQ-032 SHALL be verified with: write 0x12345678 to 0x00 then read 0x00 -> OKAY, returns ID_VALUE 0x4E505501.
REQ-033 SHALL be verified with: WAIT_STATES=0, back-to-back NONSEQ write 0x04 / read 0x04 -> hready_o stays 1, read returns the just-written data.
REQ-034 SHALL be verified with: reset asserted during WAIT of a write to 0x08 -> next cycle hready_o=1, hresp_o=0, reg 2 reads 0.

Source files
------------

// File: rtl/ahb_slave_regs.sv
// ---------------------------------------------------------------------------
// ahb_slave_regs
//   AHB-Lite slave exposing NUM_REGS 32-bit registers. Register 0 is a
//   read-only ID word; register 1 is mirrored onto ctrl_o. Every OKAY data
//   phase is stretched by WAIT_STATES wait cycles. Out-of-range, oversized
//   and misaligned transfers get the two-cycle ERROR response.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   ahb_hsel_i          : slave select
//   ahb_haddr_i         : byte address (only [7:0] decoded)
//   ahb_hwrite_i        : 1 = write
//   ahb_hsize_i         : transfer size (byte/half/word)
//   ahb_htrans_i        : IDLE/BUSY/NONSEQ/SEQ
//   ahb_hburst_i, ahb_hprot_i, ahb_hmastlock_i : accepted, ignored
//   ahb_hwdata_i        : write data, little-endian lanes
//   ahb_hready_o        : data phase complete / slave ready
//   ahb_hresp_o         : 0 = OKAY, 1 = ERROR
//   ahb_hrdata_o        : read data, nonzero only in final read data cycle
//   ctrl_o              : continuous copy of register 1
// ---------------------------------------------------------------------------
module ahb_slave_regs #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4E50_5501
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ahb_hsel_i,
  input  logic [31:0] ahb_haddr_i,
  input  logic        ahb_hwrite_i,
  input  logic [2:0]  ahb_hsize_i,
  input  logic [1:0]  ahb_htrans_i,
  input  logic [2:0]  ahb_hburst_i,
  input  logic [3:0]  ahb_hprot_i,
  input  logic        ahb_hmastlock_i,
  input  logic [31:0] ahb_hwdata_i,
  output logic        ahb_hready_o,
  output logic        ahb_hresp_o,
  output logic [31:0] ahb_hrdata_o,
  output logic [31:0] ctrl_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;
  localparam logic [2:0] WS      = 3'(WAIT_STATES);

  logic [1:0]  state;
  logic [2:0]  wcnt;
  // With zero wait states the data phase lives in IDLE; pend marks it.
  logic        pend;
  logic [7:0]  dp_addr;
  logic        dp_write;
  logic [2:0]  dp_size;
  logic [31:0] regs [1:NUM_REGS-1];

  logic        hready_int;
  logic        final_dp;
  logic        accept;
  logic        illegal;
  logic [5:0]  a_off;
  logic [5:0]  dp_off;
  logic [3:0]  strb;
  logic [31:0] rword;

  logic unused_ok;
  assign unused_ok = ^{ahb_haddr_i[31:8], ahb_htrans_i[0], ahb_hburst_i,
                       ahb_hprot_i, ahb_hmastlock_i};

  assign hready_int = !((state == ST_ERR1) || (state == ST_WAIT && wcnt != WS));
  assign final_dp   = (state == ST_WAIT && wcnt == WS) || (state == ST_IDLE && pend);
  assign accept     = ahb_hsel_i && ahb_htrans_i[1] && hready_int && !reset;
  assign a_off      = ahb_haddr_i[7:2];
  assign dp_off     = dp_addr[7:2];

  always_comb begin
    illegal = 1'b0;
    if ({26'd0, a_off} >= 32'(NUM_REGS))                      illegal = 1'b1;
    if (ahb_hsize_i > 3'b010)                                 illegal = 1'b1;
    if (ahb_hsize_i == 3'b001 && ahb_haddr_i[0])              illegal = 1'b1;
    if (ahb_hsize_i == 3'b010 && ahb_haddr_i[1:0] != 2'b00)   illegal = 1'b1;
  end

  // Control FSM. Whenever the bus is ready (IDLE, ERR2, last WAIT cycle) the
  // next state is decided purely by the address phase on the bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      pend     <= 1'b0;
      dp_addr  <= '0;
      dp_write <= 1'b0;
      dp_size  <= '0;
    end else begin
      case (state)
        ST_WAIT: if (wcnt != WS) wcnt <= wcnt + 3'd1;
        ST_ERR1: state <= ST_ERR2;
        default: ;
      endcase
      if (hready_int) begin
        state <= ST_IDLE;
        pend  <= 1'b0;
        if (accept) begin
          dp_addr  <= ahb_haddr_i[7:0];
          dp_write <= ahb_hwrite_i;
          dp_size  <= ahb_hsize_i;
          if (illegal) begin
            state <= ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state <= ST_WAIT;
            wcnt  <= '0;
          end else begin
            pend <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    case (dp_size)
      3'b000:  strb = 4'b0001 << dp_addr[1:0];
      3'b001:  strb = dp_addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Register file; index 0 is the ID constant and has no storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (final_dp && dp_write) begin
      for (int i = 1; i < NUM_REGS; i++)
        if (dp_off == 6'(i))
          for (int b = 0; b < 4; b++)
            if (strb[b]) regs[i][8*b +: 8] <= ahb_hwdata_i[8*b +: 8];
    end
  end

  always_comb begin
    rword = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++)
      if (dp_off == 6'(i)) rword = regs[i];
  end

  assign ahb_hready_o = hready_int;
  assign ahb_hresp_o  = (state == ST_ERR1) || (state == ST_ERR2);
  assign ahb_hrdata_o = (final_dp && !dp_write) ? rword : '0;
  assign ctrl_o       = regs[1];

endmodule

// File: tb/tb_ahb_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_ahb_slave_regs
//   Two instances: dut1 (WAIT_STATES=1) and dut0 (WAIT_STATES=0) sharing one
//   bus master; sel_ws0 routes hsel and picks whose response is observed.
//   The master pushes expected responses into sbq while driving address
//   phases; the monitor pops them when a data phase completes.
// ---------------------------------------------------------------------------
module tb_ahb_slave_regs;

  localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_D = 3'b011;
  localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10;

  typedef struct {
    logic        wr;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        resp;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        resp;
    logic [31:0] rdata;
    int          waits;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        hsel, hwrite, sel_ws0;
  logic [31:0] haddr, hwdata;
  logic [2:0]  hsize;
  logic [1:0]  htrans;
  logic        hready1, hresp1, hready0, hresp0;
  logic [31:0] hrdata1, hrdata0, ctrl1, ctrl0;
  logic        hready, hresp;
  logic [31:0] hrdata;

  assign hready = sel_ws0 ? hready0 : hready1;
  assign hresp  = sel_ws0 ? hresp0  : hresp1;
  assign hrdata = sel_ws0 ? hrdata0 : hrdata1;

  ahb_slave_regs #(.NUM_REGS(16), .WAIT_STATES(1), .ID_VALUE(32'h4E50_5501)) dut1 (
    .clk(clk), .reset(reset), .ahb_hsel_i(hsel & ~sel_ws0), .ahb_haddr_i(haddr),
    .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize), .ahb_htrans_i(htrans),
    .ahb_hburst_i(3'b000), .ahb_hprot_i(4'b0011), .ahb_hmastlock_i(1'b0),
    .ahb_hwdata_i(hwdata), .ahb_hready_o(hready1), .ahb_hresp_o(hresp1),
    .ahb_hrdata_o(hrdata1), .ctrl_o(ctrl1));

  ahb_slave_regs #(.NUM_REGS(16), .WAIT_STATES(0), .ID_VALUE(32'h4E50_5501)) dut0 (
    .clk(clk), .reset(reset), .ahb_hsel_i(hsel & sel_ws0), .ahb_haddr_i(haddr),
    .ahb_hwrite_i(hwrite), .ahb_hsize_i(hsize), .ahb_htrans_i(htrans),
    .ahb_hburst_i(3'b001), .ahb_hprot_i(4'b0011), .ahb_hmastlock_i(1'b0),
    .ahb_hwdata_i(hwdata), .ahb_hready_o(hready0), .ahb_hresp_o(hresp0),
    .ahb_hrdata_o(hrdata0), .ctrl_o(ctrl0));

  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];
  int   cur_ws;
  bit   mon_en;
  bit   dp_active;
  int   wait_cnt;
  bit   wait_bad;
  int   vec_idx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t V(input logic wr, input logic [1:0] tr, input logic [31:0] a,
                             input logic [2:0] sz, input logic [31:0] wd,
                             input logic rsp, input logic [31:0] rd);
    vec_t v;
    v.wr = wr; v.trans = tr; v.addr = a; v.size = sz; v.wdata = wd; v.resp = rsp; v.rdata = rd;
    return v;
  endfunction

  // Monitor: samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    if (!mon_en) begin
      dp_active = 1'b0;
      wait_cnt  = 0;
      wait_bad  = 1'b0;
    end else begin
      if (dp_active && !hready) begin
        wait_cnt++;
        if (sbq.size() > 0 && hresp !== sbq[0].resp) wait_bad = 1'b1;
        if (hrdata !== 32'h0) wait_bad = 1'b1;
      end else if (dp_active) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_underflow: got completion expected none");
        end else begin
          e = sbq.pop_front();
          chk($sformatf("resp[%0d]", e.idx),  64'(hresp),    64'(e.resp));
          chk($sformatf("rdata[%0d]", e.idx), 64'(hrdata),   64'(e.rdata));
          chk($sformatf("waits[%0d]", e.idx), 64'(wait_cnt), 64'(e.waits));
          chk($sformatf("waitbus[%0d]", e.idx), 64'(wait_bad), 64'(0));
        end
        wait_cnt = 0;
        wait_bad = 1'b0;
      end else begin
        chk("idle_bus", {30'd0, hready, hresp, hrdata}, {30'd0, 2'b10, 32'h0});
      end
      if (hready) dp_active = hsel && htrans[1];
    end
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!hready && n < 30) begin
      n++;
      @(negedge clk);
    end
    if (n >= 30) begin
      checks++; errors++;
      $display("FAIL hready_timeout: got hready=0 for %0d cycles expected 1", n);
    end
  endtask

  // Pipelined master: address of k+1 overlaps data phase of k.
  task automatic run_vecs(input vec_t v[$]);
    exp_t e;
    int   n;
    for (int k = 0; k < v.size(); k++) begin
      hsel = 1'b1; htrans = v[k].trans; hwrite = v[k].wr;
      haddr = v[k].addr; hsize = v[k].size;
      if (v[k].trans[1]) begin
        e.resp = v[k].resp; e.rdata = v[k].rdata;
        e.waits = v[k].resp ? 1 : cur_ws; e.idx = vec_idx;
        sbq.push_back(e);
      end
      vec_idx++;
      wait_ready();
      @(posedge clk); #1;
      hwdata = v[k].wdata;
    end
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0;
    n = 0;
    while (sbq.size() != 0 && n < 30) begin
      @(negedge clk); n++;
    end
    @(posedge clk); #1;
    chk("sb_drained", 64'(sbq.size()), 64'(0));
  endtask

  vec_t tab1[$];
  vec_t tab0[$];
  vec_t tab_r[$];

  initial begin
    reset = 1'b1; mon_en = 1'b0; sel_ws0 = 1'b0; cur_ws = 1; vec_idx = 0;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; haddr = '0; hsize = SZ_W; hwdata = '0;

    //              wr    trans   addr    size  wdata          resp  rdata
    tab1.push_back(V(1'b1, T_NS,   32'h04, SZ_W, 32'hDEADBEEF, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h04, SZ_W, 32'h0,        1'b0, 32'hDEADBEEF));
    tab1.push_back(V(1'b1, T_NS,   32'h08, SZ_W, 32'h11223344, 1'b0, 32'h0));
    tab1.push_back(V(1'b1, T_NS,   32'h09, SZ_B, 32'hFFFFAAFF, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h08, SZ_W, 32'h0,        1'b0, 32'h1122AA44));
    tab1.push_back(V(1'b1, T_NS,   32'h0A, SZ_H, 32'h5566FFFF, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h08, SZ_W, 32'h0,        1'b0, 32'h5566AA44));
    tab1.push_back(V(1'b0, T_NS,   32'h40, SZ_W, 32'h0,        1'b1, 32'h0));
    tab1.push_back(V(1'b1, T_NS,   32'h06, SZ_W, 32'hCAFEF00D, 1'b1, 32'h0));
    tab1.push_back(V(1'b1, T_BUSY, 32'h04, SZ_W, 32'h0BADF00D, 1'b0, 32'h0));
    tab1.push_back(V(1'b1, T_IDLE, 32'h04, SZ_W, 32'h0BADF00D, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h04, SZ_W, 32'h0,        1'b0, 32'hDEADBEEF));
    tab1.push_back(V(1'b0, T_NS,   32'h08, SZ_W, 32'h0,        1'b0, 32'h5566AA44));
    tab1.push_back(V(1'b1, T_NS,   32'h00, SZ_W, 32'h12345678, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h00, SZ_W, 32'h0,        1'b0, 32'h4E505501));
    tab1.push_back(V(1'b1, T_NS,   32'h0C, SZ_D, 32'h99999999, 1'b1, 32'h0));
    tab1.push_back(V(1'b1, T_NS,   32'h0D, SZ_H, 32'h88888888, 1'b1, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h0C, SZ_W, 32'h0,        1'b0, 32'h0));
    tab1.push_back(V(1'b1, T_NS,   32'h3C, SZ_W, 32'hA5A5A5A5, 1'b0, 32'h0));
    tab1.push_back(V(1'b0, T_NS,   32'h3C, SZ_W, 32'h0,        1'b0, 32'hA5A5A5A5));
    tab1.push_back(V(1'b0, T_NS,   32'h3E, SZ_H, 32'h0,        1'b0, 32'hA5A5A5A5));
    tab1.push_back(V(1'b0, T_NS,   32'h05, SZ_B, 32'h0,        1'b0, 32'hDEADBEEF));

    tab0.push_back(V(1'b1, T_NS,   32'h04, SZ_W, 32'h13572468, 1'b0, 32'h0));
    tab0.push_back(V(1'b0, T_NS,   32'h04, SZ_W, 32'h0,        1'b0, 32'h13572468));
    tab0.push_back(V(1'b1, T_NS,   32'h3C, SZ_W, 32'h0F0F0F0F, 1'b0, 32'h0));
    tab0.push_back(V(1'b0, T_NS,   32'h3C, SZ_W, 32'h0,        1'b0, 32'h0F0F0F0F));
    tab0.push_back(V(1'b0, T_NS,   32'h40, SZ_W, 32'h0,        1'b1, 32'h0));
    tab0.push_back(V(1'b0, T_NS,   32'h04, SZ_W, 32'h0,        1'b0, 32'h13572468));

    tab_r.push_back(V(1'b0, T_NS,  32'h08, SZ_W, 32'h0,        1'b0, 32'h0));
    tab_r.push_back(V(1'b0, T_NS,  32'h04, SZ_W, 32'h0,        1'b0, 32'h0));

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_bus1", {30'd0, hready1, hresp1, hrdata1}, {30'd0, 2'b10, 32'h0});
    chk("rst_ctrl1", 64'(ctrl1), 64'(0));
    chk("rst_bus0", {30'd0, hready0, hresp0, hrdata0}, {30'd0, 2'b10, 32'h0});
    chk("rst_ctrl0", 64'(ctrl0), 64'(0));
    #1 mon_en = 1'b1;
    @(posedge clk); #1;

    run_vecs(tab1);
    chk("ctrl1_after", 64'(ctrl1), 64'(32'hDEADBEEF));

    // Zero-wait instance: back-to-back transfers keep hready high.
    sel_ws0 = 1'b1; cur_ws = 0;
    @(posedge clk); #1;
    run_vecs(tab0);
    chk("ctrl0_after", 64'(ctrl0), 64'(32'h13572468));

    // Reset landing in the WAIT cycle of a write aborts it.
    sel_ws0 = 1'b0; cur_ws = 1; mon_en = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = T_NS; hwrite = 1'b1; haddr = 32'h08; hsize = SZ_W;
    @(negedge clk);
    chk("rst_abort_accept", 64'(hready), 64'(1));
    @(posedge clk); #1;
    hsel = 1'b0; htrans = T_IDLE; hwrite = 1'b0; hwdata = 32'h77777777;
    @(negedge clk);
    chk("rst_abort_wait", {62'd0, hready, hresp}, {62'd0, 2'b00});
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_abort_bus", {30'd0, hready, hresp, hrdata}, {30'd0, 2'b10, 32'h0});
    chk("rst_abort_ctrl", 64'(ctrl1), 64'(0));
    #1 mon_en = 1'b1;
    @(posedge clk); #1;
    run_vecs(tab_r);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
